// File: rtl/fifo_packer_pkg.sv
// Shared definitions for the width packer: state encoding, default pad value and the
// lane-index width helper.
package fifo_packer_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BURST = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StBurst = BURST,
    StFlush = FLUSH
  } state_e;

  localparam logic [31:0] DEFAULT_PAD = 32'hF0F0_F0F0;

  // Width of the lane index; never narrower than one bit.
  function automatic int unsigned lane_w(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_width_packer_if.sv
// Source (FWFT DIGIFIFO) and destination (TEMPFIFO) handshake bundle of the width packer.
// The master modport is the packer side, the slave modport the FIFO side.
interface fifo_width_packer_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned RATIO = 2,
  parameter int unsigned CNT_W = 17
);

  logic                    src_empty;
  logic [CNT_W-1:0]        src_rdcnt;
  logic [IN_W-1:0]         src_data;
  logic                    src_re;
  logic                    dst_afull;
  logic                    dst_empty;
  logic                    dst_we;
  logic [IN_W*RATIO-1:0]   dst_data;

  modport master (
    input  src_empty, src_rdcnt, src_data, dst_afull, dst_empty,
    output src_re, dst_we, dst_data
  );

  modport slave (
    output src_empty, src_rdcnt, src_data, dst_afull, dst_empty,
    input  src_re, dst_we, dst_data
  );

endinterface

// File: rtl/fifo_width_packer_run_ctrl.sv
// Run control for the width packer: input registers, daq_ready / hold latches and the
// burst start condition.
module fifo_width_packer_run_ctrl #(
  parameter int unsigned       CNT_W     = 17,
  parameter logic [CNT_W-1:0]  THRESHOLD = CNT_W'('h100)
) (
  input  logic             digiclk_i,
  input  logic             resetn_i,
  input  logic             fifo_write_mem_en,
  input  logic             last_write,
  input  logic             dst_afull,
  input  logic             dst_empty,
  input  logic [CNT_W-1:0] src_rdcnt,
  output logic             daq_ready,
  output logic             daq_fall,
  output logic             start_ok
);

  logic last_write_q, dst_empty_q;
  logic daq_ready_q, daq_ready_d;
  logic hold_q, hold_d;

  always_comb begin
    daq_ready_d = daq_ready_q;
    if (fifo_write_mem_en) begin
      daq_ready_d = 1'b1;
    end else if (last_write_q) begin
      daq_ready_d = 1'b0;
    end
    hold_d = hold_q;
    if (dst_afull) begin
      hold_d = 1'b1;
    end else if (dst_empty_q) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      last_write_q <= 1'b0;
      dst_empty_q  <= 1'b0;
      daq_ready_q  <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      last_write_q <= last_write;
      dst_empty_q  <= dst_empty;
      daq_ready_q  <= daq_ready_d;
      hold_q       <= hold_d;
    end
  end

  assign daq_ready = daq_ready_q;
  // Announced one cycle ahead of the drop so the top can latch it whatever state it is in.
  assign daq_fall  = daq_ready_q && !daq_ready_d;
  assign start_ok  = (src_rdcnt >= THRESHOLD) && !hold_q && daq_ready_q;

endmodule

// File: rtl/fifo_width_packer.sv
// Packs RATIO source words into one wide destination word, with pad-filled flush of a
// partial word. Define FIFO_PACKER_STATS_EN to add the write / flush counters.
module fifo_width_packer
  import fifo_packer_pkg::*;
#(
  parameter int unsigned       IN_W      = 32,
  parameter int unsigned       RATIO     = 2,
  parameter int unsigned       CNT_W     = 17,
  parameter logic [CNT_W-1:0]  THRESHOLD = CNT_W'('h100),
  parameter logic [IN_W-1:0]   PAD       = IN_W'(DEFAULT_PAD)
) (
  input  logic                digiclk_i,
  input  logic                resetn_i,
  fifo_width_packer_if.master bus,
  input  logic                fifo_write_mem_en,
  input  logic                last_write,
  input  logic                flush_i,
  output logic                busy_o
`ifdef FIFO_PACKER_STATS_EN
  ,
  output logic [31:0]         pkt_cnt_o,
  output logic [15:0]         flush_cnt_o
`endif
);

  localparam int unsigned     LW       = lane_w(RATIO);
  localparam logic [LW-1:0]   LastLane = LW'(RATIO - 1);

  logic daq_ready, daq_fall, start_ok;

  fifo_width_packer_run_ctrl #(
    .CNT_W     (CNT_W),
    .THRESHOLD (THRESHOLD)
  ) u_run_ctrl (
    .digiclk_i         (digiclk_i),
    .resetn_i          (resetn_i),
    .fifo_write_mem_en (fifo_write_mem_en),
    .last_write        (last_write),
    .dst_afull         (bus.dst_afull),
    .dst_empty         (bus.dst_empty),
    .src_rdcnt         (bus.src_rdcnt),
    .daq_ready         (daq_ready),
    .daq_fall          (daq_fall),
    .start_ok          (start_ok)
  );

  state_e                state_q, state_d;
  logic [LW-1:0]         lane_idx_q, lane_idx_d;
  logic [IN_W-1:0]       lanes_q [RATIO];
  logic [IN_W-1:0]       lanes_d [RATIO];
  logic                  dst_we_q, dst_we_d;
  logic [IN_W*RATIO-1:0] dst_data_q, dst_data_d;
  logic                  fall_pend_q, fall_pend_d;
  logic                  accept, flush_req, flush_wr;

  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    lanes_d     = lanes_q;
    dst_we_d    = 1'b0;
    dst_data_d  = dst_data_q;
    accept      = (state_q == StBurst) && !bus.src_empty && !bus.dst_afull;
    flush_req   = flush_i || daq_fall || fall_pend_q;
    // A daq_ready drop seen mid-burst is remembered until the packer is back in IDLE.
    fall_pend_d = !fifo_write_mem_en && (state_q != StIdle) && (fall_pend_q || daq_fall);

    unique case (state_q)
      StIdle: begin
        if ((lane_idx_q != '0) && flush_req) begin
          state_d = StFlush;
        end else if (start_ok) begin
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (bus.dst_afull || !daq_ready || bus.src_empty) begin
          state_d = StIdle;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    flush_wr = (state_q == StIdle) && (state_d == StFlush);

    if (accept) begin
      lanes_d[lane_idx_q] = bus.src_data;
      if (lane_idx_q == LastLane) begin
        lane_idx_d = '0;
        dst_we_d   = 1'b1;
        for (int unsigned i = 0; i < RATIO; i++) begin
          dst_data_d[i*IN_W +: IN_W] = lanes_d[i];
          lanes_d[i]                 = PAD;
        end
      end else begin
        lane_idx_d = lane_idx_q + LW'(1);
      end
    end

    // The padded word is registered on FLUSH entry so dst_we is high during FLUSH.
    if (flush_wr) begin
      lane_idx_d = '0;
      dst_we_d   = 1'b1;
      for (int unsigned i = 0; i < RATIO; i++) begin
        dst_data_d[i*IN_W +: IN_W] = (LW'(i) < lane_idx_q) ? lanes_q[i] : PAD;
        lanes_d[i]                 = PAD;
      end
    end
  end

  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      lane_idx_q  <= '0;
      lanes_q     <= '{default: PAD};
      dst_we_q    <= 1'b0;
      dst_data_q  <= '0;
      fall_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      lanes_q     <= lanes_d;
      dst_we_q    <= dst_we_d;
      dst_data_q  <= dst_data_d;
      fall_pend_q <= fall_pend_d;
    end
  end

  assign bus.src_re   = accept;
  assign bus.dst_we   = dst_we_q;
  assign bus.dst_data = dst_data_q;
  assign busy_o       = (state_q != StIdle);

`ifdef FIFO_PACKER_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pkt_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (fifo_write_mem_en) begin
      pkt_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (dst_we_d && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (flush_wr && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_width_packer.sv
// Directed bench for fifo_width_packer: a RATIO=2 and a RATIO=4 instance, each fed by a
// modelled FWFT source, checked against a queue model of the expected packed words.
module tb_fifo_width_packer;

  localparam logic [31:0] PadW = 32'hF0F0_F0F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_width_packer_if #(.IN_W(32), .RATIO(2), .CNT_W(17)) b2 ();
  fifo_width_packer_if #(.IN_W(32), .RATIO(4), .CNT_W(17)) b4 ();

  logic        arm2 = 0, lw2 = 0, fl2 = 0, afull2 = 0, dempty2 = 0, busy2;
  logic        arm4 = 0, lw4 = 0, fl4 = 0, afull4 = 0, dempty4 = 0, busy4;
  logic [16:0] rdcnt2 = 17'hFF, rdcnt4 = 17'hFF;

  // Source FIFO models: words popped on src_re at the clock edge.
  logic [31:0] mem2 [64];
  logic [31:0] mem4 [64];
  int          rd2 = 0, wr2 = 0, rd4 = 0, wr4 = 0;

  assign b2.src_empty = (rd2 == wr2);
  assign b2.src_data  = mem2[rd2 % 64];
  assign b2.src_rdcnt = rdcnt2;
  assign b2.dst_afull = afull2;
  assign b2.dst_empty = dempty2;
  assign b4.src_empty = (rd4 == wr4);
  assign b4.src_data  = mem4[rd4 % 64];
  assign b4.src_rdcnt = rdcnt4;
  assign b4.dst_afull = afull4;
  assign b4.dst_empty = dempty4;

  always @(posedge clk) begin
    if (b2.src_re) rd2 <= rd2 + 1;
    if (b4.src_re) rd4 <= rd4 + 1;
  end

`ifdef FIFO_PACKER_STATS_EN
  logic [31:0] pkt2, pkt4;
  logic [15:0] fc2, fc4;
`endif

  fifo_width_packer #(
    .IN_W(32), .RATIO(2), .CNT_W(17), .THRESHOLD(17'h100), .PAD(PadW)
  ) u_dut2 (
    .digiclk_i         (clk),
    .resetn_i          (rst_n),
    .bus               (b2),
    .fifo_write_mem_en (arm2),
    .last_write        (lw2),
    .flush_i           (fl2),
    .busy_o            (busy2)
`ifdef FIFO_PACKER_STATS_EN
    ,
    .pkt_cnt_o         (pkt2),
    .flush_cnt_o       (fc2)
`endif
  );

  fifo_width_packer #(
    .IN_W(32), .RATIO(4), .CNT_W(17), .THRESHOLD(17'h100), .PAD(PadW)
  ) u_dut4 (
    .digiclk_i         (clk),
    .resetn_i          (rst_n),
    .bus               (b4),
    .fifo_write_mem_en (arm4),
    .last_write        (lw4),
    .flush_i           (fl4),
    .busy_o            (busy4)
`ifdef FIFO_PACKER_STATS_EN
    ,
    .pkt_cnt_o         (pkt4),
    .flush_cnt_o       (fc4)
`endif
  );

  // Model: words pushed into a source are grouped RATIO at a time, lane 0 first.
  logic [31:0]  pend2 [$];
  logic [31:0]  pend4 [$];
  logic [127:0] exp2 [$];
  logic [127:0] exp4 [$];
  logic [127:0] log2 [$];
  logic [127:0] log4 [$];
  int           logc2 [$];
  logic         no_re2 = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic logic [127:0] join_words(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push(input int k, input logic [31:0] w);
    if (k == 2) begin
      mem2[wr2 % 64] = w;
      wr2++;
      pend2.push_back(w);
      if (pend2.size() == 2) begin
        exp2.push_back({64'd0, pend2[1], pend2[0]});
        pend2.delete();
      end
    end else begin
      mem4[wr4 % 64] = w;
      wr4++;
      pend4.push_back(w);
      if (pend4.size() == 4) begin
        exp4.push_back(join_words(pend4[0], pend4[1], pend4[2], pend4[3]));
        pend4.delete();
      end
    end
  endtask

  task automatic model_flush(input int k);
    if (k == 2 && pend2.size() != 0) begin
      while (pend2.size() < 2) pend2.push_back(PadW);
      exp2.push_back({64'd0, pend2[1], pend2[0]});
      pend2.delete();
    end else if (k == 4 && pend4.size() != 0) begin
      while (pend4.size() < 4) pend4.push_back(PadW);
      exp4.push_back(join_words(pend4[0], pend4[1], pend4[2], pend4[3]));
      pend4.delete();
    end
  endtask

  task automatic wait_idle(input int k, input string name);
    int n = 0;
    while (!((k == 2) ? (rd2 == wr2 && exp2.size() == 0) : (rd4 == wr4 && exp4.size() == 0)))
    begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, %0d expected writes outstanding", name,
                 (k == 2) ? exp2.size() : exp4.size());
        return;
      end
    end
  endtask

  task automatic pulse(ref logic sig);
    @(negedge clk);
    sig = 1'b1;
    @(negedge clk);
    sig = 1'b0;
  endtask

  // Compare process: every write against the model, data stability, src_re gating.
  logic [63:0]  prev2 = '0;
  logic [127:0] prev4 = '0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev2 = '0;
      prev4 = '0;
    end else begin
      if (b2.dst_we) begin
        log2.push_back({64'd0, b2.dst_data});
        logc2.push_back(cyc);
        if (exp2.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dst_data2: got unexpected write %h, expected no write", b2.dst_data);
        end else check("dst_data2", {64'd0, b2.dst_data}, exp2.pop_front());
      end else check("dst_data2 stable", {64'd0, b2.dst_data}, {64'd0, prev2});
      if (b4.dst_we) begin
        log4.push_back(b4.dst_data);
        if (exp4.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dst_data4: got unexpected write %h, expected no write", b4.dst_data);
        end else check("dst_data4", b4.dst_data, exp4.pop_front());
      end else check("dst_data4 stable", b4.dst_data, prev4);
      if (afull2) check("src_re2 under afull", {127'd0, b2.src_re}, 128'd0);
      if (afull4) check("src_re4 under afull", {127'd0, b4.src_re}, 128'd0);
      if (no_re2) check("src_re2 below threshold", {127'd0, b2.src_re}, 128'd0);
      prev2 = b2.dst_data;
      prev4 = b4.dst_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int arm_cyc, r0, n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset src_re2", {127'd0, b2.src_re}, 128'd0);
    check("reset dst_we2", {127'd0, b2.dst_we}, 128'd0);
    check("reset dst_data2", {64'd0, b2.dst_data}, 128'd0);
    check("reset busy2", {127'd0, busy2}, 128'd0);
    check("reset dst_data4", b4.dst_data, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // RATIO=2 basic packing, latency and throughput.
    push(2, 32'h1); push(2, 32'h2); push(2, 32'h3); push(2, 32'h4);
    rdcnt2 = 17'h100;
    @(negedge clk);
    arm2 = 1'b1;
    arm_cyc = cyc;
    @(negedge clk);
    arm2 = 1'b0;
    wait_idle(2, "basic2");
    check("pack word0", log2[0], 128'h00000002_00000001);
    check("pack word1", log2[1], 128'h00000004_00000003);
    check("pack latency", 128'(logc2[0] - arm_cyc), 128'd4);
    check("throughput", 128'(logc2[1] - logc2[0]), 128'd2);

    // Below threshold: no reads; raising the count starts the burst.
    rdcnt2 = 17'hFF;
    repeat (3) @(negedge clk);
    no_re2 = 1'b1;
    r0 = rd2;
    push(2, 32'h11); push(2, 32'h12);
    repeat (10) @(negedge clk);
    check("no read below threshold", 128'(rd2), 128'(r0));
    no_re2 = 1'b0;
    rdcnt2 = 17'h100;
    wait_idle(2, "threshold2");
    check("threshold word", log2[log2.size()-1], 128'h00000012_00000011);

    // Almost-full after one lane: immediate stop, hold until dst_empty, lane kept.
    rdcnt2 = 17'hFF;
    repeat (3) @(negedge clk);
    push(2, 32'h21); push(2, 32'h22);
    r0 = rd2;
    rdcnt2 = 17'h100;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (rd2 != r0) break;
    end
    afull2 = 1'b1;
    #1;
    check("src_re2 drops with afull", {127'd0, b2.src_re}, 128'd0);
    repeat (4) @(negedge clk);
    check("paused on afull", 128'(rd2), 128'(r0 + 1));
    afull2 = 1'b0;
    repeat (3) @(negedge clk);
    check("hold keeps paused", 128'(rd2), 128'(r0 + 1));
    dempty2 = 1'b1;
    @(negedge clk);
    dempty2 = 1'b0;
    wait_idle(2, "hold2");
    check("held lane word", log2[log2.size()-1], 128'h00000022_00000021);

    // RATIO=4: six words, last_write flushes the partial word with pad lanes.
    for (int i = 1; i <= 6; i++) push(4, 32'hA0 + 32'(i));
    rdcnt4 = 17'h100;
    pulse(arm4);
    wait_idle(4, "full4");
    rdcnt4 = 17'hFF;
    repeat (3) @(negedge clk);
    model_flush(4);
    pulse(lw4);
    wait_idle(4, "flush4");
    check("ratio4 full word", log4[0], 128'h000000A4_000000A3_000000A2_000000A1);
    check("ratio4 flush word", log4[1], {PadW, PadW, 32'hA6, 32'hA5});

    // flush_i with no partial word: no write.
    n = log4.size();
    pulse(fl4);
    repeat (6) @(negedge clk);
    check("flush on empty lane", 128'(log4.size()), 128'(n));

    // Reset mid-burst: outputs clear at once, partial word discarded.
    push(4, 32'hB1); push(4, 32'hB2); push(4, 32'hB3);
    pend4.delete();
    rdcnt4 = 17'h100;
    pulse(arm4);
    for (int i = 0; i < 50 && rd4 != wr4; i++) @(negedge clk);
    check("reset test drain", 128'(rd4), 128'(wr4));
    rst_n = 1'b0;
    #1;
    check("async reset src_re4", {127'd0, b4.src_re}, 128'd0);
    check("async reset dst_we4", {127'd0, b4.dst_we}, 128'd0);
    check("async reset dst_data4", b4.dst_data, 128'd0);
    check("async reset busy4", {127'd0, busy4}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdcnt4 = 17'hFF;
    pulse(fl4);
    repeat (6) @(negedge clk);
    check("partial discarded on reset", 128'(log4.size()), 128'(n));

    // Ten packed words plus one flush word on the RATIO=2 instance.
    rdcnt2 = 17'hFF;
    for (int i = 0; i < 21; i++) push(2, 32'h100 + 32'(i));
    pulse(arm2);
    rdcnt2 = 17'h100;
    wait_idle(2, "stats pack");
    rdcnt2 = 17'hFF;
    repeat (3) @(negedge clk);
    model_flush(2);
    pulse(fl2);
    wait_idle(2, "stats flush");
    check("stats flush word", log2[log2.size()-1], {64'd0, PadW, 32'h114});
`ifdef FIFO_PACKER_STATS_EN
    check("pkt_cnt", 128'(pkt2), 128'd11);
    check("flush_cnt", 128'(fc2), 128'd1);
    check("pkt_cnt4 after reset", 128'(pkt4), 128'd0);
    check("flush_cnt4 after reset", 128'(fc4), 128'd0);
    pulse(arm2);
    @(negedge clk);
    check("pkt_cnt cleared", 128'(pkt2), 128'd0);
    check("flush_cnt cleared", 128'(fc2), 128'd0);
`endif

    repeat (4) @(negedge clk);
    check("model2 drained", 128'(exp2.size()), 128'd0);
    check("model4 drained", 128'(exp4.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
